// File: rtl/demux_1x8_stream.sv
// Registered valid/ready 1-to-N stream demultiplexer with one holding register per channel
// and an optional round-robin destination pointer. Optional stall counter: DEMUX_STALL_CNT_EN.
`default_nettype none

module demux_1x8_stream #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    rr_mode,
    output logic [SEL_W-1:0]        rr_ptr,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [15:0]             stall_cnt
);

    logic [N_OUT-1:0]        out_valid_q;
    logic [N_OUT-1:0]        out_valid_d;
    logic [N_OUT*DATA_W-1:0] out_data_q;
    logic [N_OUT*DATA_W-1:0] out_data_d;
    logic [SEL_W-1:0]        rr_ptr_q;
    logic [SEL_W-1:0]        rr_ptr_d;
    logic                    rst_done_q;
    logic                    rst_done_d;

    logic [SEL_W-1:0]        tgt_s;
    logic                    tgt_valid_s;
    logic                    tgt_ready_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic [N_OUT-1:0]        load_s;

    // Destination channel for the word currently offered
    always_comb begin
        if (rr_mode) begin
            tgt_s = rr_ptr_q;
        end else begin
            tgt_s = in_sel;
        end
    end

    // Input handshake; rst_done_q keeps the release edge from accepting a word
    always_comb begin
        tgt_valid_s = out_valid_q[tgt_s];
        tgt_ready_s = out_ready[tgt_s];
        if (rst_n && rst_done_q) begin
            in_ready_s = !tgt_valid_s || tgt_ready_s;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Per-channel load strobes and holding-register next state
    always_comb begin
        load_s      = {N_OUT{1'b0}};
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < N_OUT; k++) begin
            load_s[k]      = accept_s && (tgt_s == SEL_W'(k));
            // A load wins over a drain, so a simultaneous drain/fill keeps valid high
            out_valid_d[k] = load_s[k] | (out_valid_q[k] & ~out_ready[k]);
            out_data_d[k*DATA_W +: DATA_W] = load_s[k] ? in_data
                                                       : out_data_q[k*DATA_W +: DATA_W];
        end
    end

    // Round-robin pointer advances only on accepts made in round-robin mode
    always_comb begin
        rst_done_d = 1'b1;
        if (accept_s && rr_mode) begin
            rr_ptr_d = rr_ptr_q + SEL_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Channel holding registers, pointer and reset-release flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= {N_OUT{1'b0}};
            out_data_q  <= {(N_OUT*DATA_W){1'b0}};
            rr_ptr_q    <= {SEL_W{1'b0}};
            rst_done_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
            rst_done_q  <= rst_done_d;
        end
    end

`ifdef DEMUX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Saturating count of cycles where a word is offered but refused
    always_comb begin
        if (in_valid && !in_ready_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign in_ready  = in_ready_s;
    assign rr_ptr    = rr_ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

`default_nettype wire
